// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: sweeps a memory to fill it with seed+address patterns, or read it back with checksum and optional pattern verification
module mem_sweep_ctrl #(
  parameter int WID_MEM   = 15,
  parameter int DEPTH_MEM = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WID_MEM-1:0] seed,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               busy,
  output logic               done,
  output logic [WID_MEM-1:0] checksum,
  output logic [15:0]        err_count,
  output logic [31:0]        first_err_addr,
  output logic               first_err_valid
);
  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_e;
  localparam logic [31:0] LAST = 32'(DEPTH_MEM - 1);
  localparam logic [31:0] NO_WR = 32'(DEPTH_MEM);
  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               vfy_q, v_q, fev_q;
  logic [WID_MEM-1:0] seed_q, chk_q;
  logic [31:0]        pa_q, fea_q;
  logic [15:0]        err_q;
  logic               last, sweeping;
  logic [WID_MEM-1:0] exp_rd;
  assign last     = addr_q == LAST;
  assign sweeping = state_q == FILL || state_q == READ;
  assign addr_d   = sweeping && !last ? addr_q + 32'd1 : '0;
  assign exp_rd   = seed_q + WID_MEM'(pa_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = start ? (mode == 2'b01 ? FILL : READ) : IDLE;
      FILL:    state_d = last ? DONE : FILL;
      READ:    state_d = last ? DRAIN : READ;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy  = state_q != IDLE;
    done  = state_q == DONE;
    raddr = state_q == READ ? addr_q : '0;
    waddr = state_q == FILL ? addr_q : NO_WR;
    din   = state_q == FILL ? seed_q + WID_MEM'(addr_q) : '0;
  end
  // v_q/pa_q delay the read address by one cycle to line up with mem_dout
  always_ff @(posedge clk) begin
    if (reset) begin
      vfy_q  <= 1'b0;
      seed_q <= '0;
      v_q    <= 1'b0;
      pa_q   <= '0;
      chk_q  <= '0;
      err_q  <= '0;
      fea_q  <= '0;
      fev_q  <= 1'b0;
    end else begin
      v_q  <= state_q == READ;
      pa_q <= addr_q;
      if (state_q == IDLE && start) begin
        vfy_q  <= mode == 2'b10;
        seed_q <= seed;
        chk_q  <= '0;
        err_q  <= '0;
        fea_q  <= '0;
        fev_q  <= 1'b0;
      end else if (v_q) begin
        chk_q <= chk_q + mem_dout;
        if (vfy_q && mem_dout != exp_rd) begin
          err_q <= err_q == 16'hFFFF ? err_q : err_q + 16'd1;
          if (!fev_q) begin
            fea_q <= pa_q;
            fev_q <= 1'b1;
          end
        end
      end
    end
  end
  assign checksum        = chk_q;
  assign err_count       = err_q;
  assign first_err_addr  = fea_q;
  assign first_err_valid = fev_q;
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: randomized self-checking bench for mem_sweep_ctrl with an attached memory and reference model
module tb_mem_sweep_ctrl;
  localparam int W = 15;
  localparam int D = 1024;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0;
  logic [1:0] mode = '0;
  logic [W-1:0] seed = '0, din, mem_dout = '0, checksum;
  logic [31:0] raddr, waddr, first_err_addr;
  logic busy, done, first_err_valid;
  logic [15:0] err_count;
  logic [W-1:0] mem [D];
  logic [W-1:0] ref_mem [D];
  logic poke_en = 1'b0;
  logic [9:0] poke_a = '0;
  logic [W-1:0] poke_v = '0;
  int tests = 0, fails = 0;
  logic [W-1:0] exp_chk;
  int exp_err, exp_fea;
  bit exp_fev;
  mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .raddr(raddr), .waddr(waddr), .din(din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .checksum(checksum), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_valid(first_err_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (waddr < D) mem[waddr[9:0]] <= din;
    else if (poke_en) mem[poke_a] <= poke_v;
    mem_dout <= raddr < D ? mem[raddr[9:0]] : '0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string name);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || waddr !== 32'(D) || raddr !== 32'd0 || din !== '0) begin
      fails++;
      $display("FAIL %s idle: busy=%b done=%b waddr=%0d raddr=%0d din=%h, want 0 0 %0d 0 0", name, busy, done, waddr, raddr, din, D);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    check_idle("reset");
    tests++;
    if (checksum !== '0 || err_count !== 16'd0 || first_err_valid !== 1'b0 || first_err_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset results: chk=%h err=%0d fev=%b fea=%0d, want all 0", checksum, err_count, first_err_valid, first_err_addr);
    end
  endtask
  task automatic test_fill(input logic [W-1:0] s, input bit poke_start);
    int bad;
    mode = 2'b01;
    seed = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    seed = W'($urandom);
    for (int a = 0; a < D; a++) begin
      tests++;
      if (waddr !== 32'(a) || din !== W'(s + a) || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL fill a=%0d: waddr=%0d din=%h busy=%b done=%b, want %0d %h 1 0", a, waddr, din, busy, done, a, W'(s + a));
      end
      start = poke_start && a == 300;
      mode = 2'b10;
      tick;
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || waddr !== 32'(D)) begin
      fails++;
      $display("FAIL fill done: done=%b busy=%b waddr=%0d, want 1 1 %0d", done, busy, waddr, D);
    end
    tick;
    check_idle("fill end");
    bad = 0;
    for (int a = 0; a < D; a++) begin
      ref_mem[a] = W'(s + a);
      if (mem[a] !== ref_mem[a]) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL fill contents: %0d words wrong, want 0", bad);
    end
  endtask
  task automatic test_sweep(input logic [1:0] m, input logic [W-1:0] s);
    exp_chk = '0;
    exp_err = 0;
    exp_fea = 0;
    exp_fev = 1'b0;
    for (int a = 0; a < D; a++) begin
      exp_chk = exp_chk + ref_mem[a];
      if (m == 2'b10 && ref_mem[a] != W'(s + a)) begin
        if (!exp_fev) exp_fea = a;
        exp_fev = 1'b1;
        exp_err++;
      end
    end
    if (exp_err > 16'hFFFF) exp_err = 16'hFFFF;
    mode = m;
    seed = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int a = 0; a < D; a++) begin
      tests++;
      if (raddr !== 32'(a) || waddr !== 32'(D) || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL sweep m=%0d a=%0d: raddr=%0d waddr=%0d busy=%b done=%b, want %0d %0d 1 0", m, a, raddr, waddr, busy, done, a, D);
      end
      tick;
    end
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || waddr !== 32'(D)) begin
      fails++;
      $display("FAIL sweep drain: done=%b busy=%b waddr=%0d, want 0 1 %0d", done, busy, waddr, D);
    end
    tick;
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || waddr !== 32'(D)) begin
      fails++;
      $display("FAIL sweep done: done=%b busy=%b waddr=%0d, want 1 1 %0d", done, busy, waddr, D);
    end
    tests++;
    if (checksum !== exp_chk || err_count !== 16'(exp_err) || first_err_valid !== exp_fev || (exp_fev && first_err_addr !== 32'(exp_fea))) begin
      fails++;
      $display("FAIL sweep m=%0d results: chk=%h err=%0d fev=%b fea=%0d, want %h %0d %b %0d", m, checksum, err_count, first_err_valid, first_err_addr, exp_chk, exp_err, exp_fev, exp_fea);
    end
    tick;
    check_idle("sweep end");
  endtask
  task automatic test_hold;
    for (int i = 0; i < 20; i++) begin
      mode = 2'($urandom);
      seed = W'($urandom);
      tick;
    end
    tests++;
    if (checksum !== exp_chk || err_count !== 16'(exp_err) || first_err_valid !== exp_fev || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold: chk=%h err=%0d fev=%b busy=%b, want %h %0d %b 0", checksum, err_count, first_err_valid, busy, exp_chk, exp_err, exp_fev);
    end
  endtask
  task automatic test_corrupt;
    for (int k = 0; k < 8; k++) begin
      poke_a = 10'($urandom_range(0, D - 1));
      poke_v = W'($urandom);
      ref_mem[poke_a] = poke_v;
      poke_en = 1'b1;
      tick;
      poke_en = 1'b0;
    end
    test_sweep(2'b10, 15'h0005);
  endtask
  task automatic test_reset_mid_fill;
    logic [W-1:0] s, old;
    s = W'($urandom_range(0, 15'h7FFE));
    old = ref_mem[101];
    mode = 2'b01;
    seed = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int a = 0; a <= 100; a++) begin
      tests++;
      if (waddr !== 32'(a)) begin
        fails++;
        $display("FAIL midfill a=%0d: waddr=%0d, want %0d", a, waddr, a);
      end
      reset = a == 100;
      tick;
    end
    reset = 1'b0;
    check_idle("midfill reset");
    tests++;
    if (checksum !== '0 || err_count !== 16'd0 || first_err_valid !== 1'b0) begin
      fails++;
      $display("FAIL midfill results: chk=%h err=%0d fev=%b, want 0 0 0", checksum, err_count, first_err_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      check_idle("midfill after");
    end
    for (int a = 0; a <= 100; a++) ref_mem[a] = W'(s + a);
    tests++;
    if (mem[100] !== W'(s + 100) || mem[101] !== old) begin
      fails++;
      $display("FAIL midfill mem: m100=%h m101=%h, want %h %h", mem[100], mem[101], W'(s + 100), old);
    end
  endtask
  task automatic test_reset_priority;
    reset = 1'b1;
    start = 1'b1;
    mode = 2'b01;
    tick;
    reset = 1'b0;
    start = 1'b0;
    check_idle("rst prio");
    tick;
    check_idle("rst prio next");
  endtask
  initial begin
    test_reset;
    test_fill(15'h0005, 1'b1);
    test_sweep(2'b10, 15'h0005);
    tests++;
    if (checksum !== 15'h1200 || err_count !== 16'd0 || first_err_valid !== 1'b0) begin
      fails++;
      $display("FAIL verify_pass: chk=%h err=%0d fev=%b, want 1200 0 0", checksum, err_count, first_err_valid);
    end
    test_sweep(2'b10, 15'h0006);
    tests++;
    if (err_count !== 16'd1024 || first_err_addr !== 32'd0 || first_err_valid !== 1'b1) begin
      fails++;
      $display("FAIL verify_bad: err=%0d fea=%0d fev=%b, want 1024 0 1", err_count, first_err_addr, first_err_valid);
    end
    test_hold;
    test_corrupt;
    test_sweep(2'b11, W'($urandom));
    test_sweep(2'b00, W'($urandom));
    test_fill(15'h7FFF, 1'b0);
    tests++;
    if (mem[0] !== 15'h7FFF || mem[1] !== 15'h0000) begin
      fails++;
      $display("FAIL wrap: m0=%h m1=%h, want 7fff 0000", mem[0], mem[1]);
    end
    test_reset_mid_fill;
    test_sweep(2'b10, 15'h7FFF);
    test_reset_priority;
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] s;
      s = W'($urandom);
      test_fill(s, 1'b1);
      test_corrupt;
      test_sweep(2'b10, s);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
